// File: rtl/stim_seq_pkg.sv
// Shared types and default widths for the stimulus sequence controller.
package stim_seq_pkg;

    localparam int STIM_SIZE_DEF = 8;
    localparam int CNT_W_DEF     = 16;
    localparam int SWEEP_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFSET,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/stim_seq_ctrl_tick_counter.sv
// Enable/clear up-counter; match flags the enabled cycle whose
// increment lands on the target value.
module tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] target,
    output logic             match
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + ONE;
        match   = en && (cnt_inc == target);
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stim_seq_ctrl.sv
// Sequences a counting stimulus pattern with programmable offset,
// step period and sweep count; start/abort/pause control.
module stim_seq_ctrl
    import stim_seq_pkg::*;
#(
    parameter int STIM_SIZE = STIM_SIZE_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SWEEP_W   = SWEEP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic [CNT_W-1:0]     cfg_offset,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic [SWEEP_W-1:0]   cfg_sweeps,
    output logic [STIM_SIZE-1:0] stim_pattern,
    output logic                 stim_valid,
    output logic [SWEEP_W-1:0]   sweep_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [STIM_SIZE-1:0] PAT_ONE = {{(STIM_SIZE-1){1'b0}}, 1'b1};
    localparam logic [SWEEP_W-1:0]   SW_ONE  = {{(SWEEP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               state_q,   state_d;
    logic [STIM_SIZE-1:0] pattern_q, pattern_d;
    logic [SWEEP_W-1:0]   sweep_q,   sweep_d;
    logic                 valid_q,   valid_d;
    logic [CNT_W-1:0]     offset_q,  offset_d;
    logic [CNT_W-1:0]     period_q,  period_d;
    logic [SWEEP_W-1:0]   sweeps_q,  sweeps_d;

    logic off_en, off_clr, off_match;
    logic per_en, per_clr, per_match;
    logic [SWEEP_W-1:0] sweep_inc;

    tick_counter #(.CNT_W(CNT_W)) u_off_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (off_en),
        .clr    (off_clr),
        .target (offset_q),
        .match  (off_match)
    );

    tick_counter #(.CNT_W(CNT_W)) u_per_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (per_en),
        .clr    (per_clr),
        .target (period_q),
        .match  (per_match)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        sweep_d   = sweep_q;
        valid_d   = 1'b0;
        offset_d  = offset_q;
        period_d  = period_q;
        sweeps_d  = sweeps_q;
        off_en    = 1'b0;
        off_clr   = 1'b0;
        per_en    = 1'b0;
        per_clr   = 1'b0;
        sweep_inc = sweep_q + SW_ONE;

        if (abort) begin
            // pattern and sweep index are left as they were for inspection
            state_d = ST_IDLE;
            off_clr = 1'b1;
            per_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        offset_d  = cfg_offset;
                        period_d  = (cfg_period == '0) ? CNT_ONE : cfg_period;
                        sweeps_d  = cfg_sweeps;
                        pattern_d = '0;
                        sweep_d   = '0;
                        off_clr   = 1'b1;
                        per_clr   = 1'b1;
                        if (cfg_sweeps == '0) begin
                            state_d = ST_DONE;
                        end else if (cfg_offset == '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_OFFSET;
                        end
                    end
                end
                ST_OFFSET: begin
                    if (!pause) begin
                        off_en = 1'b1;
                        if (off_match) begin
                            off_clr = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        per_en = 1'b1;
                        if (per_match) begin
                            per_clr   = 1'b1;
                            pattern_d = pattern_q + PAT_ONE;
                            valid_d   = 1'b1;
                            if (&pattern_q) begin
                                sweep_d = sweep_inc;
                                if (sweep_inc == sweeps_q) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            sweep_q   <= '0;
            valid_q   <= 1'b0;
            offset_q  <= '0;
            period_q  <= '0;
            sweeps_q  <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            sweep_q   <= sweep_d;
            valid_q   <= valid_d;
            offset_q  <= offset_d;
            period_q  <= period_d;
            sweeps_q  <= sweeps_d;
        end
    end

    assign stim_pattern = pattern_q;
    assign stim_valid   = valid_q;
    assign sweep_idx    = sweep_q;
    assign busy         = (state_q == ST_OFFSET) || (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// Directed table-driven bench for stim_seq_ctrl with a 3-bit pattern.
module tb_stim_seq_ctrl;

    localparam int SS = 3;
    localparam int CW = 16;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, pause;
    logic [CW-1:0] cfg_offset, cfg_period;
    logic [SW-1:0] cfg_sweeps;
    logic [SS-1:0] stim_pattern;
    logic          stim_valid;
    logic [SW-1:0] sweep_idx;
    logic          busy, done;

    always #5 clk = ~clk;

    stim_seq_ctrl #(.STIM_SIZE(SS), .CNT_W(CW), .SWEEP_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .cfg_offset   (cfg_offset),
        .cfg_period   (cfg_period),
        .cfg_sweeps   (cfg_sweeps),
        .stim_pattern (stim_pattern),
        .stim_valid   (stim_valid),
        .sweep_idx    (sweep_idx),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int off;
        int per;
        int sw;
        int p_lo;
        int p_hi;
        int a_edge;
        int s_edge;
        int budget;
        int e_done;
        int e_first;
        int e_nv;
        int e_sweep;
        int e_pat;
        int e_busy0;
        int vn;
        int ve;
    } vec_t;

    vec_t tbl[8];

    int errors = 0;
    int checks = 0;
    int done_n, first_n, nv;
    logic busy0;
    logic vmap [256];
    logic [SS-1:0] pmap [256];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, $signed(act), $signed(exp));
        end
    endtask

    // n counts samples taken on the falling edge after start edge n
    task automatic run(input vec_t v);
        int n;
        @(negedge clk);
        start      = 1'b1;
        cfg_offset = v.off[CW-1:0];
        cfg_period = v.per[CW-1:0];
        cfg_sweeps = v.sw[SW-1:0];
        for (int k = 0; k < 256; k++) begin
            vmap[k] = 1'b0;
            pmap[k] = '0;
        end
        done_n  = -1;
        first_n = -1;
        nv      = 0;
        n       = 0;
        @(negedge clk);
        start      = 1'b0;
        cfg_offset = CW'($urandom);
        cfg_period = CW'($urandom);
        cfg_sweeps = SW'($urandom);
        busy0      = busy;
        while (n < v.budget) begin
            vmap[n] = stim_valid;
            pmap[n] = stim_pattern;
            if (stim_valid) begin
                nv++;
                if (first_n < 0) first_n = n;
            end
            if (done) begin
                done_n = n;
                break;
            end
            pause = (n + 1 >= v.p_lo) && (n + 1 <= v.p_hi);
            abort = (n + 1 == v.a_edge);
            start = (n + 1 == v.s_edge);
            @(negedge clk);
            n++;
        end
        pause = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        int pc;
        string s;
        run(v);
        s = $sformatf("v%0d", idx);
        chk({s, "_done_cycle"}, done_n, v.e_done);
        chk({s, "_first_valid"}, first_n, v.e_first);
        chk({s, "_valid_count"}, nv, v.e_nv);
        chk({s, "_sweep_idx"}, 32'(sweep_idx), v.e_sweep);
        chk({s, "_pattern"}, 32'(stim_pattern), v.e_pat);
        chk({s, "_busy_end"}, 32'(busy), 0);
        chk({s, "_busy_t0"}, 32'(busy0), v.e_busy0);
        chk({s, "_pat_cleared"}, 32'(pmap[0]), 0);
        chk({s, "_valid_at"}, 32'(vmap[v.vn]), v.ve);
        if (v.e_first >= 0) begin
            chk({s, "_first_pat"}, 32'(pmap[v.e_first]), 1);
        end
        if (v.p_lo >= 0) begin
            pc = 0;
            for (int k = v.p_lo; k <= v.p_hi; k++) pc += int'(vmap[k]);
            chk({s, "_no_valid_paused"}, pc, 0);
        end
        if (v.e_done >= 0) begin
            @(negedge clk);
            chk({s, "_done_one_cycle"}, 32'(done), 0);
        end
    endtask

    initial begin
        //          off per sw plo phi  ab  st bud  done fst nv swp pat b0 vn ve
        tbl[0] = '{5, 10, 1, -1, -2, -1,  3, 200, 85, 15,  8, 1, 0, 1, 25, 1};
        tbl[1] = '{0,  0, 2, -1, -2, -1, -1, 200, 16,  1, 16, 2, 0, 1, 16, 1};
        tbl[2] = '{0,  0, 0, -1, -2, -1, -1, 200,  0, -1,  0, 0, 0, 0,  0, 0};
        tbl[3] = '{0,  4, 1, 10, 12, -1, -1, 200, 35,  4,  8, 1, 0, 1, 15, 1};
        tbl[4] = '{2,  3, 1, -1, -2, 20, -1,  30, -1,  5,  5, 0, 5, 1, 20, 0};
        tbl[5] = '{0,  1, 1, -1, -2, -1, -1, 200,  8,  1,  8, 1, 0, 1,  8, 1};
        tbl[6] = '{2,  1, 3, -1, -2, -1, -1, 200, 26,  3, 24, 3, 0, 1, 26, 1};
        tbl[7] = '{3,  4, 1, -1, -2, -1, 10, 200, 35,  7,  8, 1, 0, 1, 11, 1};

        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pause      = 1'b0;
        cfg_offset = '0;
        cfg_period = '0;
        cfg_sweeps = '0;
        repeat (2) @(negedge clk);
        chk("rst_pattern", 32'(stim_pattern), 0);
        chk("rst_valid", 32'(stim_valid), 0);
        chk("rst_sweep", 32'(sweep_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i], i);
        end

        // reset while waiting out the offset
        @(negedge clk);
        cfg_offset = 16'd20;
        cfg_period = 16'd2;
        cfg_sweeps = 8'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("offset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_off_busy", 32'(busy), 0);
        chk("rst_off_done", 32'(done), 0);
        chk("rst_off_pattern", 32'(stim_pattern), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of stepping
        @(negedge clk);
        cfg_offset = 16'd0;
        cfg_period = 16'd1;
        cfg_sweeps = 8'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("run_pattern", 32'(stim_pattern), 4);
        chk("run_valid", 32'(stim_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_run_pattern", 32'(stim_pattern), 0);
        chk("rst_run_valid", 32'(stim_valid), 0);
        chk("rst_run_busy", 32'(busy), 0);
        chk("rst_run_sweep", 32'(sweep_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(tbl[5], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
